// File: rtl/count_svsg_core.sv
// count_svsg_core: prescaled decimal (0-9) counter driving a seven-segment
// pattern onto user pads. Segment byte is {a,b,c,d,e,f,g,dp}, active-high.
// seg_out is a register fed from the current digit, so it lags digit by one edge.
module count_svsg_core #(
  parameter int DIV   = 16,
  parameter int DIV_W = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       count_en,
  input  logic       clear,
  output logic [7:0] seg_out,
  output logic [7:0] io_oeb,
  output logic [3:0] digit
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);
  localparam logic [7:0]       SEG_ZERO   = 8'hFC;

  logic [DIV_W-1:0] r_presc;
  logic [3:0]       r_digit;
  logic [7:0]       r_seg;
  logic             w_tick;
  logic [7:0]       w_seg_next;

  // One-cycle tick on the enabled edge where the prescaler completes a period
  assign w_tick = count_en && (r_presc == PRESC_LAST);

  // Prescaler and digit state; reset beats clear beats count_en
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear) begin
      r_presc <= '0;
      r_digit <= 4'd0;
    end else if (count_en) begin
      if (w_tick) begin
        r_presc <= '0;
        r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Seven-segment decode of the current digit; dp is never lit and any
  // unreachable code blanks the display
  always_comb begin
    w_seg_next = 8'h00;
    case (r_digit)
      4'd0: w_seg_next = 8'hFC;
      4'd1: w_seg_next = 8'h60;
      4'd2: w_seg_next = 8'hDA;
      4'd3: w_seg_next = 8'hF2;
      4'd4: w_seg_next = 8'h66;
      4'd5: w_seg_next = 8'hB6;
      4'd6: w_seg_next = 8'hBE;
      4'd7: w_seg_next = 8'hE0;
      4'd8: w_seg_next = 8'hFE;
      4'd9: w_seg_next = 8'hF6;
      default: w_seg_next = 8'h00;
    endcase
  end

  // Segment register: follows the digit one edge later. Clear is not applied
  // here, so after a clear the old digit's pattern shows for one more edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_seg <= SEG_ZERO;
    else          r_seg <= w_seg_next;
  end

  assign seg_out = r_seg;
  assign digit   = r_digit;
  assign io_oeb  = 8'h00;  // all eight pads are driven outputs

endmodule

// File: tb/tb_count_svsg_core.sv
// Directed bench for count_svsg_core: DIV=4 main instance plus DIV=1 and
// DIV=16 instances for the prescaler boundary cases.
module tb_count_svsg_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en4 = 1'b0, en1 = 1'b0, en16 = 1'b0;
  logic [7:0] seg4, seg1, seg16, oeb4, oeb1, oeb16;
  logic [3:0] dig4, dig1, dig16;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] enc [0:9];

  always #5 clk = ~clk;

  count_svsg_core #(.DIV(4), .DIV_W(16)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .count_en(en4), .clear(clr),
    .seg_out(seg4), .io_oeb(oeb4), .digit(dig4));

  count_svsg_core #(.DIV(1), .DIV_W(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .count_en(en1), .clear(clr),
    .seg_out(seg1), .io_oeb(oeb1), .digit(dig1));

  count_svsg_core #(.DIV(16), .DIV_W(16)) dut16 (
    .wb_clk_i(clk), .wb_rst_i(rst), .count_en(en16), .clear(clr),
    .seg_out(seg16), .io_oeb(oeb16), .digit(dig16));

  // advance one rising edge; inputs change and outputs are read 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en4 = 1'b1; clr = 1'b0;
    step(); step();
    n_chk++; if (dig4 !== 4'd0) $display("FAIL reset_digit got %h exp 0", dig4); else n_pass++;
    n_chk++; if (seg4 !== 8'hFC) $display("FAIL reset_seg got %h exp FC", seg4); else n_pass++;
    n_chk++; if (oeb4 !== 8'h00) $display("FAIL reset_oeb got %h exp 00", oeb4); else n_pass++;
    n_chk++; if (dig16 !== 4'd0 || seg16 !== 8'hFC)
      $display("FAIL reset_div16 got %h/%h exp 0/FC", dig16, seg16); else n_pass++;
    rst = 1'b0;
  endtask

  // DIV=4: digit k after enabled edge 4k, its pattern on edge 4k+1
  task automatic test_sequence();
    repeat (3) step();
    for (int k = 1; k <= 10; k++) begin
      step();
      n_chk++; if (dig4 !== 4'(k % 10))
        $display("FAIL seq_digit k=%0d got %0d exp %0d", k, dig4, k % 10); else n_pass++;
      n_chk++; if (seg4 !== enc[(k - 1) % 10])
        $display("FAIL seq_seg_lag k=%0d got %h exp %h", k, seg4, enc[(k - 1) % 10]); else n_pass++;
      step();
      n_chk++; if (seg4 !== enc[k % 10])
        $display("FAIL seq_seg k=%0d got %h exp %h", k, seg4, enc[k % 10]); else n_pass++;
      repeat (2) step();
    end
  endtask

  // hold at digit 5 / prescaler 2, then resume: prescaler 3, then tick to 6
  task automatic test_hold();
    clr = 1'b1; step(); clr = 1'b0;      // digit 0, prescaler 0
    repeat (22) step();                  // digit 5, prescaler 2
    en4 = 1'b0;
    repeat (10) step();
    n_chk++; if (dig4 !== 4'd5 || seg4 !== 8'hB6)
      $display("FAIL hold_keep got %0d/%h exp 5/B6", dig4, seg4); else n_pass++;
    en4 = 1'b1;
    step();
    n_chk++; if (dig4 !== 4'd5)
      $display("FAIL hold_partial got %0d exp 5", dig4); else n_pass++;
    step();
    n_chk++; if (dig4 !== 4'd6)
      $display("FAIL hold_resume got %0d exp 6", dig4); else n_pass++;
    step();
    n_chk++; if (seg4 !== 8'hBE)
      $display("FAIL hold_seg got %h exp BE", seg4); else n_pass++;
  endtask

  // state now: digit 6, prescaler 1
  task automatic test_clear();
    repeat (3) step();                   // digit 7, prescaler 0
    n_chk++; if (dig4 !== 4'd7)
      $display("FAIL clear_setup got %0d exp 7", dig4); else n_pass++;
    clr = 1'b1; step(); clr = 1'b0;
    n_chk++; if (dig4 !== 4'd0)
      $display("FAIL clear_digit got %0d exp 0", dig4); else n_pass++;
    n_chk++; if (seg4 !== 8'hE0)
      $display("FAIL clear_seg_lag got %h exp E0", seg4); else n_pass++;
    step();
    n_chk++; if (seg4 !== 8'hFC)
      $display("FAIL clear_seg got %h exp FC", seg4); else n_pass++;
    step(); step();                      // 3 enabled edges since clear
    n_chk++; if (dig4 !== 4'd0)
      $display("FAIL clear_restart_early got %0d exp 0", dig4); else n_pass++;
    step();                              // 4th edge: first tick
    n_chk++; if (dig4 !== 4'd1)
      $display("FAIL clear_restart got %0d exp 1", dig4); else n_pass++;
  endtask

  // state: digit 1, prescaler 0; reset applied on an edge that would tick
  task automatic test_reset_vs_tick();
    repeat (3) step();                   // prescaler 3
    rst = 1'b1; clr = 1'b0; en4 = 1'b1;
    step();
    rst = 1'b0; en4 = 1'b0;
    n_chk++; if (dig4 !== 4'd0)
      $display("FAIL rst_vs_tick_digit got %0d exp 0", dig4); else n_pass++;
    n_chk++; if (seg4 !== 8'hFC)
      $display("FAIL rst_vs_tick_seg got %h exp FC", seg4); else n_pass++;
  endtask

  // DIV=1: every enabled edge is a tick
  task automatic test_div1();
    rst = 1'b1; step(); rst = 1'b0;
    en1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_chk++; if (dig1 !== 4'(i % 10))
        $display("FAIL div1_digit i=%0d got %0d exp %0d", i, dig1, i % 10); else n_pass++;
      n_chk++; if (seg1 !== enc[(i - 1) % 10])
        $display("FAIL div1_seg i=%0d got %h exp %h", i, seg1, enc[(i - 1) % 10]); else n_pass++;
    end
    en1 = 1'b0;
    n_chk++; if (oeb1 !== 8'h00) $display("FAIL div1_oeb got %h exp 00", oeb1); else n_pass++;
  endtask

  // DIV=16: digit 9 after 144 enabled edges, F6 on the pads at edge 145
  task automatic test_div16();
    rst = 1'b1; step(); rst = 1'b0;
    en16 = 1'b1;
    repeat (144) step();
    n_chk++; if (dig16 !== 4'd9 || seg16 !== 8'hFE)
      $display("FAIL div16_144 got %0d/%h exp 9/FE", dig16, seg16); else n_pass++;
    step();
    n_chk++; if (seg16 !== 8'hF6)
      $display("FAIL div16_145 got %h exp F6", seg16); else n_pass++;
    en16 = 1'b0;
    n_chk++; if (oeb16 !== 8'h00) $display("FAIL div16_oeb got %h exp 00", oeb16); else n_pass++;
  endtask

  initial begin
    enc[0] = 8'hFC; enc[1] = 8'h60; enc[2] = 8'hDA; enc[3] = 8'hF2; enc[4] = 8'h66;
    enc[5] = 8'hB6; enc[6] = 8'hBE; enc[7] = 8'hE0; enc[8] = 8'hFE; enc[9] = 8'hF6;
    #2;
    test_reset();
    test_sequence();
    test_hold();
    test_clear();
    test_reset_vs_tick();
    test_div1();
    test_div16();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
